// File: rtl/result_pack_pkg.sv
// -----------------------------------------------------------------------------
// result_pack_pkg
// Shared types and constants for the result pack writer: FSM state encoding,
// the legal element widths and the elements-per-word lookup.
// -----------------------------------------------------------------------------
package result_pack_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PACK,
      ST_FLUSH,
      ST_HEADER,
      ST_DONE
   } state_t;

   localparam logic [4:0] SIZE_2  = 5'd2;
   localparam logic [4:0] SIZE_4  = 5'd4;
   localparam logic [4:0] SIZE_8  = 5'd8;
   localparam logic [4:0] SIZE_16 = 5'd16;

   // Any width other than 2/4/8 is run as a full 16-bit element.
   function automatic logic [4:0] legal_size(input logic [4:0] s);
      case (s)
         SIZE_2, SIZE_4, SIZE_8: return s;
         default:                return SIZE_16;
      endcase
   endfunction

   // Number of elements that fit in one 16-bit word for a legal width.
   function automatic logic [3:0] elems_per_word(input logic [4:0] s);
      case (s)
         SIZE_2:  return 4'd8;
         SIZE_4:  return 4'd4;
         SIZE_8:  return 4'd2;
         default: return 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/result_saturate.sv
// -----------------------------------------------------------------------------
// result_saturate
// Combinational clip of a signed 16-bit result to a signed S-bit range, with
// the S-bit result returned zero-extended in the low bits.
//   i_size : legal element width (2, 4, 8 or 16)
//   i_data : signed two's-complement input
//   o_data : clipped value, low i_size bits valid, upper bits zero
// -----------------------------------------------------------------------------
module result_saturate
   import result_pack_pkg::*;
(
   input  logic [4:0]        i_size,
   input  logic [WORD_W-1:0] i_data,
   output logic [WORD_W-1:0] o_data
);

   logic signed [WORD_W:0]   w_data;
   logic signed [WORD_W:0]   w_max;
   logic signed [WORD_W:0]   w_min;
   logic signed [WORD_W:0]   w_clip;
   logic        [WORD_W-1:0] w_mask;

   always_comb begin
      // NOTE: combinational blocks use blocking assignments and give every
      // output a value on every path so no latch is inferred.
      w_data = {i_data[WORD_W-1], i_data};
      w_max  = (17'sd1 <<< (i_size - 5'd1)) - 17'sd1;
      w_min  = -(17'sd1 <<< (i_size - 5'd1));
      w_mask = 16'hFFFF >> (5'd16 - i_size);
      if (w_data > w_max) begin
         w_clip = w_max;
      end else if (w_data < w_min) begin
         w_clip = w_min;
      end else begin
         w_clip = w_data;
      end
      o_data = w_clip[WORD_W-1:0] & w_mask;
   end

endmodule

// File: rtl/result_pack_writer.sv
// -----------------------------------------------------------------------------
// result_pack_writer
// Saturates a stream of signed 16-bit results to the run's element width,
// packs them LSB-first into 16-bit words written from BASE_ADDR+1 upward, then
// writes the element count as a header word at BASE_ADDR and pulses done.
//   clk, reset              : clock, asynchronous active-high reset
//   start, elem_size        : run start pulse and element width (2/4/8/16)
//   in_valid/in_ready       : element handshake; in_data, in_last qualify it
//   dut_sram_write_*        : registered SRAM write port
//   busy, done              : run in progress, one-cycle completion pulse
// -----------------------------------------------------------------------------
module result_pack_writer
   import result_pack_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [4:0]        elem_size,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic [ADDR_W-1:0] dut_sram_write_address,
   output logic [DATA_W-1:0] dut_sram_write_data,
   output logic              dut_sram_write_enable,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] HEADER_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] DATA_START  = ADDR_W'(BASE_ADDR + 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [4:0]          r_size;
   logic [DATA_W-1:0]   r_buf;
   logic [3:0]          r_fill;
   logic [15:0]         r_count;
   logic [ADDR_W-1:0]   r_ptr;

   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_busy;
   logic                r_done;

   logic                w_hs;
   logic [3:0]          w_fill_inc;
   logic                w_word_full;
   logic [3:0]          w_offset;
   logic [DATA_W-1:0]   w_sat;
   logic [DATA_W-1:0]   w_buf_ins;

   logic                w_we_nxt;
   logic [ADDR_W-1:0]   w_waddr_nxt;
   logic [DATA_W-1:0]   w_wdata_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;

   result_saturate u_sat (
      .i_size (r_size),
      .i_data (in_data),
      .o_data (w_sat)
   );

   assign in_ready    = (r_state == ST_PACK);
   assign w_hs        = in_valid & in_ready;
   assign w_fill_inc  = r_fill + 4'd1;
   assign w_word_full = (w_fill_inc == elems_per_word(r_size));
   // Offsets never exceed 14, so the truncated product is exact.
   assign w_offset    = 4'(r_fill * r_size);
   assign w_buf_ins   = r_buf | (w_sat << w_offset);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of its inputs.
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_PACK;
         ST_PACK:   if (w_hs && in_last) w_state_nxt = ST_FLUSH;
         ST_FLUSH:  w_state_nxt = ST_HEADER;
         ST_HEADER: w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Computes the values loaded into the output registers. The data word for a
   // full or final handshake is registered at that same edge, so the write is
   // visible in the following cycle (the FLUSH cycle for the last element).
   always_comb begin
      w_we_nxt    = 1'b0;
      w_waddr_nxt = r_waddr;
      w_wdata_nxt = r_wdata;
      case (r_state)
         ST_PACK: begin
            if (w_hs && (w_word_full || in_last)) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = r_ptr;
               w_wdata_nxt = w_buf_ins;
            end
         end
         ST_FLUSH: begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = HEADER_ADDR;
            w_wdata_nxt = DATA_W'(r_count);
         end
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt == ST_PACK) || (w_state_nxt == ST_FLUSH) ||
                   (w_state_nxt == ST_HEADER);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_we    <= w_we_nxt;
         r_waddr <= w_waddr_nxt;
         r_wdata <= w_wdata_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign dut_sram_write_enable  = r_we;
   assign dut_sram_write_address = r_waddr;
   assign dut_sram_write_data    = r_wdata;
   assign busy                   = r_busy;
   assign done                   = r_done;

   // ---------------- pack datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_size  <= SIZE_16;
         r_buf   <= '0;
         r_fill  <= '0;
         r_count <= '0;
         r_ptr   <= DATA_START;
      end else if (r_state == ST_IDLE) begin
         if (start) begin
            r_size  <= legal_size(elem_size);
            r_buf   <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_ptr   <= DATA_START;
         end
      end else if (w_hs) begin
         r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
         if (w_word_full || in_last) begin
            r_buf  <= '0;
            r_fill <= '0;
            r_ptr  <= r_ptr + 1'b1;
         end else begin
            r_buf  <= w_buf_ins;
            r_fill <= w_fill_inc;
         end
      end
   end

endmodule

// File: tb/tb_result_pack_writer.sv
// -----------------------------------------------------------------------------
// tb_result_pack_writer
// Directed bench for result_pack_writer: each run drives a short element list,
// captures every SRAM write and compares against hand-computed words, header
// and handshake/done timing.
// -----------------------------------------------------------------------------
module tb_result_pack_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  elem_size;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic [11:0] dut_sram_write_address;
   logic [15:0] dut_sram_write_data;
   logic        dut_sram_write_enable;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_cyc   = 0;

   logic [15:0] q_addr[$];
   logic [15:0] q_data[$];
   int          q_cyc[$];

   logic [15:0] vec[16];
   logic [15:0] exp_a[4];
   logic [15:0] exp_d[4];

   result_pack_writer #(.ADDR_W(12), .DATA_W(16), .BASE_ADDR(0)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .elem_size              (elem_size),
      .in_valid               (in_valid),
      .in_ready               (in_ready),
      .in_data                (in_data),
      .in_last                (in_last),
      .dut_sram_write_address (dut_sram_write_address),
      .dut_sram_write_data    (dut_sram_write_data),
      .dut_sram_write_enable  (dut_sram_write_enable),
      .busy                   (busy),
      .done                   (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dut_sram_write_enable) begin
         q_addr.push_back({4'h0, dut_sram_write_address});
         q_data.push_back(dut_sram_write_data);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [4:0] size);
      q_addr.delete(); q_data.delete(); q_cyc.delete();
      start = 1'b1; elem_size = size;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Presents one element and returns one step after the accepting edge.
   task automatic push(input logic [15:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("hs_timeout", 0, 1);
      hs_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_case(input string name, input logic [4:0] size, input int n,
                           input bit gaps, input int n_exp);
      do_start(size);
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) begin
            @(posedge clk); #1;
         end
         push(vec[i], i == n - 1);
      end
      // t+1 .. t+4 after the last handshake
      @(negedge clk);
      check({name, "_busy_t1"},  busy, 1);
      check({name, "_rdy_t1"},   in_ready, 0);
      @(negedge clk);
      check({name, "_busy_t2"},  busy, 1);
      check({name, "_rdy_t2"},   in_ready, 0);
      @(negedge clk);
      check({name, "_done_t3"},  done, 1);
      check({name, "_busy_t3"},  busy, 0);
      check({name, "_rdy_t3"},   in_ready, 0);
      @(negedge clk);
      check({name, "_done_t4"},  done, 0);
      check({name, "_rdy_t4"},   in_ready, 0);
      check({name, "_nwr"}, q_addr.size(), n_exp);
      for (int i = 0; i < n_exp; i++) begin
         check($sformatf("%s_addr%0d", name, i), (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, exp_a[i]);
         check($sformatf("%s_data%0d", name, i), (i < q_data.size()) ? q_data[i] : 16'hxxxx, exp_d[i]);
      end
      if (q_cyc.size() >= 2) begin
         check({name, "_flush_lat"}, q_cyc[q_cyc.size()-2] - hs_cyc, 1);
         check({name, "_hdr_lat"},   q_cyc[q_cyc.size()-1] - hs_cyc, 2);
      end else begin
         check({name, "_too_few_wr"}, q_cyc.size(), 2);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_we"},   dut_sram_write_enable, 0);
      check({name, "_addr"}, dut_sram_write_address, 0);
      check({name, "_data"}, dut_sram_write_data, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_done"}, done, 0);
      check({name, "_rdy"},  in_ready, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; elem_size = 5'd4;
      in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("rst");
      reset = 1'b0;
      @(posedge clk); #1;

      // size 4: 1,2,3,4
      vec[0] = 16'd1; vec[1] = 16'd2; vec[2] = 16'd3; vec[3] = 16'd4;
      exp_a[0] = 16'd1; exp_d[0] = 16'h4321;
      exp_a[1] = 16'd0; exp_d[1] = 16'h0004;
      run_case("s4", 5'd4, 4, 1'b0, 2);

      // size 8: 300, -200, 5 (started right at t+4)
      vec[0] = 16'd300; vec[1] = 16'hFF38; vec[2] = 16'd5;
      exp_a[0] = 16'd1; exp_d[0] = 16'h807F;
      exp_a[1] = 16'd2; exp_d[1] = 16'h0005;
      exp_a[2] = 16'd0; exp_d[2] = 16'h0003;
      run_case("s8", 5'd8, 3, 1'b0, 3);

      // size 2: nine ones
      for (int i = 0; i < 9; i++) vec[i] = 16'd1;
      exp_a[0] = 16'd1; exp_d[0] = 16'h5555;
      exp_a[1] = 16'd2; exp_d[1] = 16'h0001;
      exp_a[2] = 16'd0; exp_d[2] = 16'h0009;
      run_case("s2", 5'd2, 9, 1'b0, 3);

      // size 4: eight sevens with in_valid toggling
      for (int i = 0; i < 8; i++) vec[i] = 16'd7;
      exp_a[0] = 16'd1; exp_d[0] = 16'h7777;
      exp_a[1] = 16'd2; exp_d[1] = 16'h7777;
      exp_a[2] = 16'd0; exp_d[2] = 16'h0008;
      run_case("s4gap", 5'd4, 8, 1'b1, 3);

      // illegal size 5 runs as 16
      vec[0] = 16'h8000; vec[1] = 16'h7FFF;
      exp_a[0] = 16'd1; exp_d[0] = 16'h8000;
      exp_a[1] = 16'd2; exp_d[1] = 16'h7FFF;
      exp_a[2] = 16'd0; exp_d[2] = 16'h0002;
      run_case("s5", 5'd5, 2, 1'b0, 3);

      // reset after two handshakes
      do_start(5'd4);
      push(16'd1, 1'b0);
      push(16'd1, 1'b0);
      reset = 1'b1;
      #1;
      check_outputs_zero("midrst");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_nwr", q_addr.size(), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) vec[i] = 16'd1;
      exp_a[0] = 16'd1; exp_d[0] = 16'h1111;
      exp_a[1] = 16'd0; exp_d[1] = 16'h0004;
      run_case("after_rst", 5'd4, 4, 1'b0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/result_pack_writer.md
# result_pack_writer

Downstream stage of the input/weight accumulation datapath. It accepts a stream of signed 16-bit results, saturates each one to the configured element width (2, 4, 8 or 16 bits), and packs the elements LSB-first into 16-bit words. Packed words are written to the output SRAM starting at `BASE_ADDR+1`. On the last element it flushes any partial word, writes the element count as a header word at `BASE_ADDR`, then pulses `done`.

## Interface
- `ADDR_W`, 12, SRAM address width
- `DATA_W`, 16, SRAM word width and result width
- `BASE_ADDR`, 0, header address; data words start at `BASE_ADDR+1`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a run and latches `elem_size`
- `elem_size`  in  5  element width in bits: 2, 4, 8 or 16; any other value is treated as 16
- `in_valid`  in  1  `in_data` and `in_last` are valid
- `in_ready`  out  1  block accepts an element this cycle
- `in_data`  in  16  signed two's-complement result
- `in_last`  in  1  marks the final element of the run
- `dut_sram_write_address`  out  ADDR_W  output SRAM write address
- `dut_sram_write_data`  out  DATA_W  output SRAM write data
- `dut_sram_write_enable`  out  1  write strobe, one cycle per word
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: `in_ready=0`. On `start`, latch size, clear buffer/fill/count, set `ptr=BASE_ADDR+1`, go to PACK.
  - PACK: `in_ready=1`. A handshake is `in_valid & in_ready`.
  - FLUSH, HEADER, DONE: `in_ready=0`.
- Per handshake:
  - Saturate `in_data` to the signed range [-2^(S-1), 2^(S-1)-1], where S is the latched size.
  - Insert the low S bits at bit offset `fill*S`.
  - `fill++`, `count++`. `count` is 16 bits and saturates at 0xFFFF.
- Word full (`fill` reaches 16/S) and not last: next cycle write the buffer to `ptr`, `ptr++`, clear buffer and `fill`, stay in PACK.
- Handshake with `in_last=1`: go to FLUSH.
  - FLUSH writes the buffer to `ptr`. The buffer is never empty here; unused high bits are 0.
  - HEADER writes `count` to `BASE_ADDR`.
  - DONE asserts `done=1`, `busy=0`, then returns to IDLE.
- `ptr` wraps modulo 2^ADDR_W.
- `start` outside IDLE is ignored.
- Reset mid-run: immediate return to IDLE; nothing is written; the partial buffer is discarded.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- Reset values: `dut_sram_write_enable=0`, `dut_sram_write_address=0`, `dut_sram_write_data=0`, `busy=0`, `done=0`, `in_ready=0`.
- `busy` is 1 from the cycle after `start` through the HEADER cycle.
- Throughput: one element per cycle in PACK; the word write overlaps the next accept.
- Write latency: a handshake at cycle t that fills a word produces `write_enable=1` at t+1.
- Last handshake at t:
  - t+1: final data write
  - t+2: header write
  - t+3: `done=1`, `busy=0`
  - t+4: IDLE; `start` is accepted from t+4.
- `write_enable` is high for exactly one cycle per word and is never asserted in IDLE or DONE.

## Structure
- Package `result_pack_pkg`:
  - state enum (IDLE, PACK, FLUSH, HEADER, DONE)
  - legal size constants (2, 4, 8, 16)
  - `ELEMS_PER_WORD` lookup per size
- One sub-module, `result_saturate`: combinational clip of a 16-bit signed value to the selected width, output zero-extended low bits.
- Top level contains the FSM, pack buffer, `fill` and `count` counters, and the address pointer.

## Test plan
- Size 4, inputs 1, 2, 3, 4 back-to-back, last on 4 -> write addr 1 = 0x4321, addr 0 = 0x0004, `done` 3 cycles after the last handshake.
- Size 8, inputs 300, -200, 5, last on 5 -> addr 1 = 0x807F, addr 2 = 0x0005, addr 0 = 0x0003.
- Size 2, nine inputs of 1 -> addr 1 = 0x5555, addr 2 = 0x0001, addr 0 = 0x0009.
- Size 4, eight inputs of 7 with `in_valid` toggled every other cycle -> addr 1 = addr 2 = 0x7777, addr 0 = 0x0008; `in_ready` low from the cycle after last until IDLE.
- `elem_size=5`, inputs 0x8000 then 0x7FFF -> treated as 16: addr 1 = 0x8000, addr 2 = 0x7FFF, addr 0 = 0x0002.
- Size 4, reset asserted after 2 handshakes -> all outputs 0 immediately, no write; a new `start` with 4 inputs of 1 gives addr 1 = 0x1111, addr 0 = 0x0004.
